// File: rtl/vga_pkg.sv
// Shared definitions for the VGA sync controller: phase-state enum,
// default 640x480@60 timing and the derived line/frame totals.
package vga_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } vga_phase_e;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;

  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: a wrapping position counter plus the ACTIVE/FRONT/SYNC/BACK
// phase FSM. Used once for pixels within a line and once for lines in a frame.
//
//   state  | meaning
//   ACTIVE | count inside the visible area
//   FRONT  | front porch
//   SYNC   | sync pulse (sync_n_o low)
//   BACK   | back porch, ends at the wrap back to 0
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int unsigned ACT = DEF_H_ACTIVE,
  parameter int unsigned FP  = DEF_H_FP,
  parameter int unsigned SYN = DEF_H_SYNC,
  parameter int unsigned BP  = DEF_H_BP,
  parameter int unsigned W   = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         step_i,
  output logic [W-1:0] cnt_o,
  output logic         sync_n_o,
  output logic         active_nxt_o,
  output logic         last_o
);

  localparam int unsigned TOT = ACT + FP + SYN + BP;
  localparam logic [W-1:0] LAST_ACT = W'(ACT - 1);
  localparam logic [W-1:0] LAST_FP  = W'(ACT + FP - 1);
  localparam logic [W-1:0] LAST_SYN = W'(ACT + FP + SYN - 1);
  localparam logic [W-1:0] LAST_TOT = W'(TOT - 1);

  logic [W-1:0] cnt_q, cnt_d;
  vga_phase_e   state_q, state_d;
  logic         sync_n_q, sync_n_d;

  // Counter next value: clear wins, otherwise step and wrap at the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = (cnt_q == LAST_TOT) ? '0 : cnt_q + 1'b1;
    end
  end

  // Phase FSM: leave each phase on the step taken from its last count.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = ACTIVE;
    end else if (step_i) begin
      case (state_q)
        ACTIVE:  if (cnt_q == LAST_ACT) state_d = FRONT;
        FRONT:   if (cnt_q == LAST_FP)  state_d = SYNC;
        SYNC:    if (cnt_q == LAST_SYN) state_d = BACK;
        BACK:    if (cnt_q == LAST_TOT) state_d = ACTIVE;
        default: state_d = ACTIVE;
      endcase
    end
    sync_n_d = (state_d != SYNC);
  end

  // Axis registers; sync is kept as its own flop so the pin is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      state_q  <= ACTIVE;
      sync_n_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      sync_n_q <= sync_n_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign sync_n_o     = sync_n_q;
  assign active_nxt_o = (state_d == ACTIVE);
  assign last_o       = (cnt_q == LAST_TOT);

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA sync generator: horizontal and vertical axis counters advanced by the
// pixel-rate enable, with registered sync, blanking and start-of-line/frame
// pulses. Optional frame counter under macro VGA_SYNC_FRAME_CNT_EN.
//
//   state   | meaning
//   idle    | run_q=0: counters parked at (0,0), video off, waiting for a tick
//   running | run_q=1: every qualifying tick advances the raster position
module vga_sync_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_en,
  input  logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  logic h_clr, v_clr, h_step, v_step;
  logic h_last, v_last, h_act_nxt, v_act_nxt;
  logic h_sync_n, v_sync_n;
  logic run_q, run_d;
  logic ls_q, ls_d, fs_q, fs_d;
  logic video_q, video_d;

  vga_axis_cnt #(
    .ACT(H_ACTIVE), .FP(H_FP), .SYN(H_SYNC), .BP(H_BP), .W(CNT_W)
  ) u_h_axis (
    .clk          (clk),
    .rst_n        (reset),
    .clr_i        (h_clr),
    .step_i       (h_step),
    .cnt_o        (pixel_x),
    .sync_n_o     (h_sync_n),
    .active_nxt_o (h_act_nxt),
    .last_o       (h_last)
  );

  vga_axis_cnt #(
    .ACT(V_ACTIVE), .FP(V_FP), .SYN(V_SYNC), .BP(V_BP), .W(CNT_W)
  ) u_v_axis (
    .clk          (clk),
    .rst_n        (reset),
    .clr_i        (v_clr),
    .step_i       (v_step),
    .cnt_o        (pixel_y),
    .sync_n_o     (v_sync_n),
    .active_nxt_o (v_act_nxt),
    .last_o       (v_last)
  );

  // Run control: enable low parks both axes at once; the first tick after
  // start re-presents (0,0) as a fresh frame instead of advancing.
  always_comb begin
    h_clr  = 1'b0;
    v_clr  = 1'b0;
    h_step = 1'b0;
    v_step = 1'b0;
    run_d  = run_q;
    ls_d   = 1'b0;
    fs_d   = 1'b0;
    if (!enable) begin
      h_clr = 1'b1;
      v_clr = 1'b1;
      run_d = 1'b0;
    end else if (tick_en) begin
      if (!run_q) begin
        h_clr = 1'b1;
        v_clr = 1'b1;
        run_d = 1'b1;
        ls_d  = 1'b1;
        fs_d  = 1'b1;
      end else begin
        h_step = 1'b1;
        v_step = h_last;
        ls_d   = h_last;
        fs_d   = h_last & v_last;
      end
    end
  end

  // Visible-area flag follows the axes' next phase so it lines up with the counts.
  always_comb begin
    video_d = video_q;
    if (!enable) begin
      video_d = 1'b0;
    end else if (tick_en) begin
      video_d = h_act_nxt & v_act_nxt;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q   <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      video_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      video_q <= video_d;
    end
  end

  assign hsync       = h_sync_n;
  assign vsync       = v_sync_n;
  assign video_on    = video_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] fc_q, fc_d;

  // Frame counter bumps alongside each frame_start pulse and wraps naturally.
  always_comb begin
    fc_d = fs_d ? fc_q + 16'd1 : fc_q;
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fc_q <= '0;
    end else begin
      fc_q <= fc_d;
    end
  end

  assign frame_count = fc_q;
`else
  // Frame counter not built.
`endif

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Scoreboard bench for vga_sync_ctrl using a reduced raster so several
// frames fit in a short run. The driver updates a position-level reference
// model each clock and queues the expected outputs; a monitor on the falling
// edge pops and compares.
module tb_vga_sync_ctrl;

  localparam int HA = 16, HFP = 2, HS = 3, HB = 4;
  localparam int VA = 6,  VFP = 2, VS = 2, VB = 3;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vid;
    logic       ls;
    logic       fs;
    logic [9:0] px;
    logic [9:0] py;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, tick_en, enable;
  logic       hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic [15:0] frame_count;

  vga_sync_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_en     (tick_en),
    .enable      (enable),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

`ifndef VGA_SYNC_FRAME_CNT_EN
  initial frame_count = 16'h0;
  localparam bit FC_EN = 1'b0;
`else
  localparam bit FC_EN = 1'b1;
`endif

  int n_chk = 0;
  int n_fail = 0;
  obs_t exp_q[$];

  // reference model: raster position, running flag and pulses
  int m_h, m_v;
  bit m_run, m_ls, m_fs;
  logic [15:0] m_fc;
  bit p_r, p_e, p_t;

  function automatic void model_reset();
    m_h = 0; m_v = 0; m_run = 0; m_ls = 0; m_fs = 0; m_fc = 16'h0;
  endfunction

  function automatic void model_edge(input bit r, input bit e, input bit t);
    m_ls = 0; m_fs = 0;
    if (!r) begin
      model_reset();
    end else if (!e) begin
      m_h = 0; m_v = 0; m_run = 0;
    end else if (t) begin
      if (!m_run) begin
        m_run = 1; m_h = 0; m_v = 0;
      end else begin
        m_h = m_h + 1;
        if (m_h == HT) begin
          m_h = 0;
          m_v = m_v + 1;
          if (m_v == VT) m_v = 0;
        end
      end
      m_ls = (m_h == 0);
      m_fs = (m_h == 0) && (m_v == 0);
      if (m_fs) m_fc = m_fc + 16'd1;
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.hs  = !(m_h >= HA + HFP && m_h < HA + HFP + HS);
    o.vs  = !(m_v >= VA + VFP && m_v < VA + VFP + VS);
    o.vid = m_run && (m_h < HA) && (m_v < VA);
    o.ls  = m_ls;
    o.fs  = m_fs;
    o.px  = 10'(m_h);
    o.py  = 10'(m_v);
    o.fc  = FC_EN ? m_fc : 16'h0;
    return o;
  endfunction

  // one clock: apply the edge just taken to the model, drive new inputs,
  // honour an immediate reset, queue what the monitor should see next
  task automatic drive_cycle(input bit r, input bit e, input bit t);
    @(posedge clk);
    #1;
    model_edge(p_r, p_e, p_t);
    reset   = r;
    enable  = e;
    tick_en = t;
    if (!r) model_reset();
    exp_q.push_back(model_obs());
    p_r = r; p_e = e; p_t = t;
  endtask

  task automatic tick_group(input bit e);
    drive_cycle(1'b1, e, 1'b1);
    repeat (3) drive_cycle(1'b1, e, 1'b0);
  endtask

  task automatic run_until(input int th, input int tv);
    int n;
    n = 0;
    while (!(m_run && m_h == th && m_v == tv)) begin
      if (n > HT * VT + 8) begin
        n_chk++;
        n_fail++;
        $display("FAIL run_until_timeout target=(%0d,%0d) model=(%0d,%0d)", th, tv, m_h, m_v);
        return;
      end
      tick_group(1'b1);
      n++;
    end
  endtask

  // monitor
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.hs = hsync; a.vs = vsync; a.vid = video_on;
        a.ls = line_start; a.fs = frame_start;
        a.px = pixel_x; a.py = pixel_y;
        a.fc = FC_EN ? frame_count : 16'h0;
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t actual hs=%b vs=%b vid=%b ls=%b fs=%b x=%0d y=%0d fc=%0d required hs=%b vs=%b vid=%b ls=%b fs=%b x=%0d y=%0d fc=%0d",
                   $time, a.hs, a.vs, a.vid, a.ls, a.fs, a.px, a.py, a.fc,
                   e.hs, e.vs, e.vid, e.ls, e.fs, e.px, e.py, e.fc);
        end
      end
    end
  end

  // stimulus
  initial begin
    bit cur_e, r, t;
    int gap;
    reset = 1'b0; enable = 1'b0; tick_en = 1'b0;
    p_r = 0; p_e = 0; p_t = 0;
    model_reset();

    repeat (3) drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0);

    // start-up and a bit over two frames at the nominal tick spacing
    repeat (2 * HT * VT + HT + 5) tick_group(1'b1);

    // stall ticks right before the horizontal sync boundary
    run_until(HA + HFP - 1, 2);
    repeat (50) drive_cycle(1'b1, 1'b1, 1'b0);
    repeat (2) tick_group(1'b1);

    // drop enable mid-frame, with stray ticks while disabled, then restart
    run_until(5, 3);
    drive_cycle(1'b1, 1'b0, 1'b1);
    repeat (6) drive_cycle(1'b1, 1'b0, bit'($urandom_range(0, 1)));
    drive_cycle(1'b1, 1'b1, 1'b0);
    repeat (5) tick_group(1'b1);

    // reset during the last vsync line, then two full frames
    run_until(3, VA + VFP + VS - 1);
    drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b0);
    repeat (2 * HT * VT + 1) tick_group(1'b1);

    // randomized tick spacing, enable drops and occasional reset pulses
    cur_e = 1'b1;
    gap = 4;
    for (int i = 0; i < 20000; i++) begin
      if (cur_e && $urandom_range(0, 4999) == 0) cur_e = 1'b0;
      else if (!cur_e && $urandom_range(0, 39) == 0) cur_e = 1'b1;
      r = ($urandom_range(0, 2999) != 0);
      t = (gap >= 3) && ($urandom_range(0, 2) == 0);
      gap = t ? 0 : gap + 1;
      drive_cycle(r, cur_e, t);
    end

    drive_cycle(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain leftover=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_ctrl.md
VGA_SYNC_CTRL -- requirements
Module: vga_sync_ctrl

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch in pixel ticks.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync and back porch in lines.
REQ-005 Port clk, input, 1, 100 MHz system clock.
REQ-006 Port reset, input, 1, asynchronous active-low reset: 0 resets, 1 runs.
REQ-007 Port tick_en, input, 1, 25 MHz pixel-rate enable, one clk wide, at most one per 4 clk.
REQ-008 Port enable, input, 1, run control; 0 holds the timing in idle.
REQ-009 Port hsync / vsync, output, 1 each, active-low sync pulses.
REQ-010 Port video_on, output, 1, high while the pixel is inside the visible area.
REQ-011 Port pixel_x / pixel_y, output, 10 each, current horizontal and vertical count.
REQ-012 Port line_start / frame_start, output, 1 each, single-clk pulses.

Function
REQ-013 All outputs shall be registered; counters shall advance only on a clk edge where tick_en=1 and enable=1.
REQ-014 Horizontal count h shall run 0..H_TOTAL-1 (800) and wrap to 0; vertical count v shall increment only on the tick where h wraps.
REQ-015 v shall run 0..V_TOTAL-1 (525) and wrap to 0 on the same tick that h wraps; this simultaneous wrap is a single event.
REQ-016 The horizontal phase FSM shall have states ACTIVE (h<640), FRONT (640..655), SYNC (656..751) and BACK (752..799), stepping ACTIVE->FRONT->SYNC->BACK->ACTIVE at the phase boundaries.
REQ-017 The vertical phase FSM shall use the same four states over v: ACTIVE <480, FRONT 480..489, SYNC 490..491, BACK 492..524.
REQ-018 hsync shall be 0 exactly while the horizontal FSM is in SYNC; vsync shall be 0 exactly while the vertical FSM is in SYNC.
REQ-019 video_on shall be 1 exactly when both FSMs are in ACTIVE.
REQ-020 pixel_x shall equal h and pixel_y shall equal v, with no added latency relative to hsync, vsync and video_on.
REQ-021 line_start shall pulse for one clk on the edge where h becomes 0.
REQ-022 frame_start shall pulse for one clk on the edge where h and v both become 0; line_start shall also pulse on that edge.
REQ-023 With tick_en=0, all outputs shall hold and the pulses shall be 0.
REQ-024 enable falling to 0 shall force the idle state on the next clk regardless of tick_en: counters 0, both FSMs ACTIVE, hsync=1, vsync=1, video_on=0, pulses 0.
REQ-025 enable rising to 1 shall start at (0,0) on the first qualifying tick, and shall emit line_start and frame_start on that tick.

Reset
REQ-026 reset=0 shall immediately force pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=0, line_start=0 and frame_start=0, with both FSMs in ACTIVE.
REQ-027 Reset asserted mid-frame shall abandon the frame; after release, behaviour shall be as in REQ-025.

Configuration
REQ-028 Macro VGA_SYNC_FRAME_CNT_EN: when defined, the block shall add output frame_count[15:0], reset to 0, incremented on each frame_start and wrapping 0xFFFF->0.
REQ-029 When VGA_SYNC_FRAME_CNT_EN is undefined, the frame_count port and its logic shall not exist.

Structure
REQ-030 A shared package vga_pkg shall hold the phase-state enum (ACTIVE, FRONT, SYNC, BACK), the default timing constants, and H_TOTAL/V_TOTAL as sums of the four segments.
REQ-031 The single sub-module vga_axis_cnt (parameterised counter plus phase FSM with wrap output) shall be instantiated twice, once for horizontal and once for vertical.

Verification
REQ-032 Reset release, enable=1, tick_en every 4 clk -> first tick gives line_start=1, frame_start=1, pixel (0,0), video_on=1.
REQ-033 Run one line -> hsync=0 for exactly 96 ticks starting at h=656; video_on=0 from h=640; line_start repeats every 800 ticks (3200 clk).
REQ-034 Run one full frame -> vsync=0 for 2 lines at v=490..491; next frame_start occurs 420000 ticks (1,680,000 clk) after the previous one.
REQ-035 Hold tick_en=0 for 50 clk at h=655 -> all outputs frozen; the next tick gives h=656, hsync=0.
REQ-036 Drop enable at v=300, h=100 -> next clk is idle per REQ-024; re-enable -> restart at (0,0) with frame_start.
REQ-037 Assert reset at v=491 (vsync=0) -> vsync=1 immediately; with VGA_SYNC_FRAME_CNT_EN, frame_count=0 and reads 2 after two full frames.
